// File: rtl/ssd_display_driver_if.sv
// Display-side bus of the seven-segment driver: value in, scanned digit pins out.
interface ssd_display_driver_if #(
  parameter int unsigned WIDTH = 13
);
  logic [WIDTH-1:0] num;
  logic [3:0]       anode;
  logic [6:0]       seg;
  logic             busy;

  modport master (output num, input anode, seg, busy);
  modport slave  (input num, output anode, seg, busy);
endinterface

// File: rtl/ssd_display_driver.sv
// Binary-to-BCD (sequential double-dabble) plus a 4-digit multiplexed
// common-anode seven-segment scanner with optional leading-zero blanking.
module ssd_display_driver #(
  parameter int unsigned WIDTH        = 13,
  parameter int unsigned REFRESH_BITS = 18,
  parameter bit          BLANK_LZ     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  ssd_display_driver_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned BCD_W = 16;
  localparam int unsigned SH_W  = BCD_W + WIDTH;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state;
  logic [WIDTH-1:0]        cur_val;
  logic [WIDTH-1:0]        bin_sr;
  logic [BCD_W-1:0]        bcd_sr;
  logic [CNT_W-1:0]        cnt;
  logic [3:0]              d0, d1, d2, d3;
  logic                    busy_r;
  logic [REFRESH_BITS-1:0] refresh;
  logic [3:0]              anode_r;
  logic [6:0]              seg_r;

  logic [BCD_W-1:0]        adj_c;
  logic [SH_W-1:0]         sh_c;
  logic [1:0]              sel_c;
  logic [3:0]              digit_c;
  logic                    blank_c;
  logic [3:0]              anode_c;
  logic [6:0]              seg_c;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes render blank.
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  // Double-dabble step: add-3 correction on every nibble, then shift left.
  always_comb begin
    adj_c = bcd_sr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5)
        adj_c[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
    sh_c = {adj_c, bin_sr} << 1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cur_val <= '0;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      cnt     <= '0;
      d0      <= '0;
      d1      <= '0;
      d2      <= '0;
      d3      <= '0;
      busy_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.num != cur_val) begin
            cur_val <= bus.num;
            bin_sr  <= bus.num;
            bcd_sr  <= '0;
            cnt     <= CNT_W'(WIDTH);
            busy_r  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_sr <= sh_c[SH_W-1:WIDTH];
          bin_sr <= sh_c[WIDTH-1:0];
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state <= DONE;
        end
        DONE: begin
          {d3, d2, d1, d0} <= bcd_sr;
          busy_r           <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit select from the top two refresh bits; blanked digits keep their anode.
  always_comb begin
    sel_c   = refresh[REFRESH_BITS-1 -: 2];
    anode_c = 4'b1111;
    digit_c = d0;
    blank_c = 1'b0;
    case (sel_c)
      2'd0: begin
        anode_c = 4'b1110;
        digit_c = d0;
      end
      2'd1: begin
        anode_c = 4'b1101;
        digit_c = d1;
        blank_c = BLANK_LZ && (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0);
      end
      2'd2: begin
        anode_c = 4'b1011;
        digit_c = d2;
        blank_c = BLANK_LZ && (d3 == 4'd0) && (d2 == 4'd0);
      end
      default: begin
        anode_c = 4'b0111;
        digit_c = d3;
        blank_c = BLANK_LZ && (d3 == 4'd0);
      end
    endcase
    seg_c = blank_c ? 7'b1111111 : enc(digit_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh <= '0;
      anode_r <= 4'b1111;
      seg_r   <= 7'b1111111;
    end else begin
      refresh <= refresh + REFRESH_BITS'(1);
      anode_r <= anode_c;
      seg_r   <= seg_c;
    end
  end

  assign bus.anode = anode_r;
  assign bus.seg   = seg_r;
  assign bus.busy  = busy_r;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Directed bench for ssd_display_driver: conversion latency, digit scan,
// blanking, mid-conversion value change and asynchronous reset.
module tb_ssd_display_driver;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ssd_display_driver_if #(.WIDTH(13)) b0 ();
  ssd_display_driver_if #(.WIDTH(13)) b1 ();

  ssd_display_driver #(.WIDTH(13), .REFRESH_BITS(4), .BLANK_LZ(1'b1)) dut_lz (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  ssd_display_driver #(.WIDTH(13), .REFRESH_BITS(4), .BLANK_LZ(1'b0)) dut_all (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count negedges with busy high for one conversion; bounded.
  task automatic run_busy(input int which, output int n);
    logic b;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      b = (which != 0) ? b1.busy : b0.busy;
      if (b) n++;
      else if (n > 0) break;
    end
  endtask

  // Wait (bounded) for a digit's anode, then check its segments.
  task automatic expect_digit(input int which, input string tag,
                              input logic [3:0] an, input logic [6:0] s);
    logic [3:0] a;
    logic [6:0] sg;
    a  = 4'b1111;
    sg = 7'b1111111;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a  = (which != 0) ? b1.anode : b0.anode;
      sg = (which != 0) ? b1.seg : b0.seg;
      if (a == an) break;
    end
    chk({tag, "_an"}, 32'(a), 32'(an));
    chk(tag, 32'(sg), 32'(s));
  endtask

  function automatic logic [6:0] seg_1234(input logic [3:0] an);
    case (an)
      4'b1110: seg_1234 = 7'b0011001;
      4'b1101: seg_1234 = 7'b0110000;
      4'b1011: seg_1234 = 7'b0100100;
      4'b0111: seg_1234 = 7'b1111001;
      default: seg_1234 = 7'b0000000;
    endcase
  endfunction

  initial begin
    int n;
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    b0.num  = 13'd0;
    b1.num  = 13'd0;

    repeat (3) @(negedge clk);
    chk("rst_anode", 32'(b0.anode), 32'(4'b1111));
    chk("rst_seg",   32'(b0.seg),   32'(7'b1111111));
    chk("rst_busy",  32'(b0.busy),  32'(1'b0));

    rst = 1'b1;
    @(negedge clk);
    chk("rel_anode", 32'(b0.anode), 32'(4'b1110));
    chk("rel_seg",   32'(b0.seg),   32'(7'b1000000));
    chk("rel_busy",  32'(b0.busy),  32'(1'b0));
    expect_digit(0, "zero_tens",  4'b1101, 7'b1111111);
    expect_digit(0, "zero_hund",  4'b1011, 7'b1111111);
    expect_digit(0, "zero_thou",  4'b0111, 7'b1111111);
    expect_digit(1, "nolz_thou0", 4'b0111, 7'b1000000);

    b0.num = 13'd1234;
    run_busy(0, n);
    chk("busy_1234", 32'(n), 32'd14);
    expect_digit(0, "d1234_ones", 4'b1110, 7'b0011001);
    expect_digit(0, "d1234_tens", 4'b1101, 7'b0110000);
    expect_digit(0, "d1234_hund", 4'b1011, 7'b0100100);
    expect_digit(0, "d1234_thou", 4'b0111, 7'b1111001);

    b0.num = 13'd7;
    run_busy(0, n);
    chk("busy_7", 32'(n), 32'd14);
    expect_digit(0, "d7_thou", 4'b0111, 7'b1111111);
    expect_digit(0, "d7_hund", 4'b1011, 7'b1111111);
    expect_digit(0, "d7_tens", 4'b1101, 7'b1111111);
    expect_digit(0, "d7_ones", 4'b1110, 7'b1111000);

    b0.num = 13'd8191;
    run_busy(0, n);
    chk("busy_8191", 32'(n), 32'd14);
    expect_digit(0, "d8191_thou", 4'b0111, 7'b0000000);
    expect_digit(0, "d8191_hund", 4'b1011, 7'b1111001);
    expect_digit(0, "d8191_tens", 4'b1101, 7'b0010000);
    expect_digit(0, "d8191_ones", 4'b1110, 7'b1111001);

    // Change the value on the fifth SHIFT cycle of a running conversion.
    b0.num = 13'd1234;
    repeat (5) @(negedge clk);
    b0.num = 13'd5678;
    run_busy(0, n);
    chk("mid_busy1", 32'(n + 5), 32'd14);
    @(negedge clk);
    chk("mid_gap_busy", 32'(b0.busy), 32'(1'b1));
    chk("mid_gap_seg",  32'(b0.seg),  32'(seg_1234(b0.anode)));
    run_busy(0, n);
    chk("mid_busy2", 32'(n + 1), 32'd14);
    expect_digit(0, "d5678_thou", 4'b0111, 7'b0010010);
    expect_digit(0, "d5678_hund", 4'b1011, 7'b0000010);
    expect_digit(0, "d5678_tens", 4'b1101, 7'b1111000);
    expect_digit(0, "d5678_ones", 4'b1110, 7'b0000000);

    // Asynchronous reset in the middle of a conversion.
    b0.num = 13'd4321;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_anode", 32'(b0.anode), 32'(4'b1111));
    chk("arst_seg",   32'(b0.seg),   32'(7'b1111111));
    chk("arst_busy",  32'(b0.busy),  32'(1'b0));
    @(negedge clk);
    rst = 1'b1;
    run_busy(0, n);
    chk("busy_4321", 32'(n), 32'd14);
    expect_digit(0, "d4321_thou", 4'b0111, 7'b0011001);
    expect_digit(0, "d4321_hund", 4'b1011, 7'b0110000);
    expect_digit(0, "d4321_tens", 4'b1101, 7'b0100100);
    expect_digit(0, "d4321_ones", 4'b1110, 7'b1111001);

    // No leading-zero blanking.
    b1.num = 13'd5;
    run_busy(1, n);
    chk("busy_nolz5", 32'(n), 32'd14);
    expect_digit(1, "nolz_thou", 4'b0111, 7'b1000000);
    expect_digit(1, "nolz_hund", 4'b1011, 7'b1000000);
    expect_digit(1, "nolz_tens", 4'b1101, 7'b1000000);
    expect_digit(1, "nolz_ones", 4'b1110, 7'b0010010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_display_driver.md
Name: ssd_display_driver

Overview:
- Consumes the 13-bit debug value that the CPU top drives onto its SSD bus and renders it on a 4-digit, common-anode seven-segment display.
- Converts binary to decimal BCD with a sequential double-dabble engine.
- Holds the converted digits stable and time-multiplexes the four digits with a free-running refresh counter.
- Sits on the board top level, between the CPU's SSD output and the display pins.

Parameters:
- WIDTH, 13, bit width of num. Legal range 1..13, so the maximum value 8191 fits in 4 digits.
- REFRESH_BITS, 18, width of the refresh counter. The top 2 bits select the active digit; the bench uses 4.
- BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all four digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- num  in  WIDTH  unsigned binary value to display.
- anode  out  4  digit enables, active-low. Bit 0 = ones, bit 3 = thousands.
- seg  out  7  segments, active-low, order {g,f,e,d,c,b,a}.
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - anode=4'b1111, seg=7'b1111111, busy=0.
  - Refresh counter=0, state=IDLE, cur_val=0, digit registers d3..d0=0.
  - Reset is effective mid-conversion; any partial result is discarded.
- Conversion FSM, states IDLE, SHIFT, DONE:
  - IDLE: if num != cur_val at a clock edge: cur_val<=num, bin_sr<=num, bcd_sr<=16'h0000, cnt<=WIDTH, go to SHIFT, busy<=1. Otherwise stay.
  - SHIFT: each cycle, first add 3 to each bcd_sr nibble that is >=5, then shift {bcd_sr,bin_sr} left by 1 and decrement cnt. When cnt reaches 1 on entry to the cycle, go to DONE after this shift. SHIFT therefore lasts exactly WIDTH cycles.
  - DONE: {d3,d2,d1,d0}<=bcd_sr, busy<=0, go to IDLE.
  - Latency: digit registers update WIDTH+1 edges after the capture edge. busy is high for exactly WIDTH+1 cycles. seg reflects new digits one further edge later.
  - num is ignored outside IDLE. A change during SHIFT/DONE is detected in the next IDLE cycle and starts a fresh conversion.
  - The displayed digits only ever come from complete conversions; never mixed or partial.
  - After reset, num=0 matches cur_val, so no conversion occurs and the display shows 0.
- Scan:
  - The refresh counter increments every clk and wraps at 2^REFRESH_BITS.
  - sel = counter[REFRESH_BITS-1:REFRESH_BITS-2].
  - sel=0: anode 1110, digit d0. sel=1: anode 1101, d1. sel=2: anode 1011, d2. sel=3: anode 0111, d3.
  - anode and seg are registered and lag sel by one cycle.
- Segment encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Blank=1111111.
- Blanking (BLANK_LZ=1):
  - d3 is blanked if d3==0.
  - d2 is blanked if d3==0 and d2==0.
  - d1 is blanked if d3, d2 and d1 are all 0.
  - d0 is never blanked.
  - The anode for a blanked digit is still asserted; only seg goes blank.

Test Plan (REFRESH_BITS=4, so each digit is shown for 4 cycles):
- Reset hold: rst=0 → anode=1111, seg=1111111, busy=0. Release → next edge anode=1110, seg=1000000, and all other digits blank.
- num=1234 → busy high for 14 cycles, then low. Scan then shows ones=0011001 (4), tens=0110000 (3), hundreds=0100100 (2), thousands=1111001 (1).
- num=7 → thousands, hundreds and tens seg=1111111 with their anodes still cycling; ones=1111000. Then num=8191 → digits 8, 1, 9, 1 (0000000, 1111001, 0010000, 1111001).
- Mid-conversion change: num=1234, then num=5678 on the 5th SHIFT cycle → digits show 1234 after the first DONE, then busy goes high again and digits show 5678. No other digit combination may appear.
- Reset mid-conversion: num=4321, assert rst during SHIFT → outputs take reset values immediately, with no clock needed. After release with num still 4321, a new conversion runs and the display shows 4321.
- BLANK_LZ=0, num=5 → all four digits are driven; thousands, hundreds and tens show 1000000, ones shows 0010010.
